inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch (IF) stage of the five-stage MIPS pipeline. It owns the program counter, drives the instruction SRAM read port, and produces `if_to_id_bus` = {ce, pc}, which ID registers one cycle later alongside the returned `inst_sram_rdata`. It accepts ID's `br_bus` redirect. A redirect that arrives while IF is stalled is held in a pending register, so it is never lost when ID inserts a bubble.

## Interface
- RESET_PC, 32'hBFC0_0000, address of the first instruction fetched after reset
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- stall  in  `StallBus` (6)  pipeline stall vector; bit 0 = IF hold (`Stop`=1, `NoStop`=0)
- br_bus  in  `BR_WD` (33)  {br_e, br_addr[31:0]} from ID, combinational, same cycle
- if_to_id_bus  out  `IF_TO_ID_WD` (33)  {ce, pc[31:0]}
- inst_sram_en  out  1  read enable, equals ce
- inst_sram_wen  out  4  constant 4'b0000
- inst_sram_addr  out  32  fetch address, equals pc
- inst_sram_wdata  out  32  constant 32'b0
- fetch_cnt  out  32  count of edges at which a new fetch address was issued (perf counter)

## Operation
- State registers: pc_reg[31:0], ce_reg, br_pend, br_pend_addr[31:0], fetch_cnt.
- Reset values:
  - pc_reg = RESET_PC − 4 = 32'hBFBF_FFFC
  - ce_reg = 0, br_pend = 0, br_pend_addr = 0, fetch_cnt = 0
  - Resulting outputs during reset: if_to_id_bus = {1'b0, 32'hBFBF_FFFC}, inst_sram_en = 0.
- next_pc selection, priority high to low:
  1. live br_e = 1 → br_addr
  2. br_pend = 1 → br_pend_addr
  3. otherwise → pc_reg + 32'h4, mod 2^32 (wraps 32'hFFFF_FFFC → 0)
- Advance edge (stall[0] == NoStop):
  - pc_reg ← next_pc, ce_reg ← 1
  - br_pend ← 0
  - fetch_cnt ← fetch_cnt + 1, wrapping at 2^32
- Hold edge (stall[0] == Stop):
  - pc_reg, ce_reg and fetch_cnt unchanged.
  - If br_e = 1: br_pend ← 1, br_pend_addr ← br_addr. A later br_e during the same stall overwrites the captured address.
  - If br_e = 0: the pending registers are unchanged.
- Outputs are pure wires from registers: inst_sram_en = ce_reg, inst_sram_addr = pc_reg, if_to_id_bus = {ce_reg, pc_reg}.
- Target alignment is not checked. Addresses are passed through unmodified; ID supplies word-aligned targets.
- rst asserted mid-operation, including with a redirect pending, restores every reset value at that edge; the pending redirect is discarded.

## Timing
- IF has no combinational path from br_bus or stall to any output; all outputs change only at clk edges.
- Redirect latency: br_e sampled at edge N (not stalled) → inst_sram_addr = br_addr after edge N. ID receives the instruction at edge N+1.
- The delay slot is naturally fetched: the instruction at pc+4 is already in flight when the branch is decoded in ID.
- First fetch: the first non-stalled edge after rst deasserts drives addr = 32'hBFC0_0000, ce = 1.
- The SRAM read has one-cycle latency: data for inst_sram_addr at cycle N is valid in cycle N+1, when ID holds that pc.
- A stall of any length with no br_e keeps addr, ce and fetch_cnt constant.
- Redirect and stall release on the same edge: the live br_addr wins over the pending address, and the pending flag clears.

## Test plan
- Reset then free-run with stall = 0: addr sequence BFC0_0000, BFC0_0004, BFC0_0008; ce = 1 from the first post-reset edge; fetch_cnt = 3 after 3 edges.
- br_bus = {1, 32'hBFC0_0100} for one cycle while running → next addr BFC0_0100, then BFC0_0104.
- stall[0] = 1 for 3 cycles with a br_e pulse {1, 32'h8000_0040} in the 2nd cycle, br_e = 0 thereafter → addr frozen for 3 cycles, then 8000_0040 on release; fetch_cnt unchanged during the stall.
- Pending 8000_0040 captured, then on the release edge live br_e = {1, 32'h8000_0080} → addr 8000_0080; br_pend = 0 afterwards.
- pc_reg = FFFF_FFFC with no branch → next addr 0000_0000.
- rst pulsed while br_pend = 1 → all outputs at reset values; the first fetch after release is BFC0_0000, not the pending target.

Source files
------------

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : MIPS IF stage - PC register, instruction SRAM read port and
//            held-over branch redirect for redirects that arrive during a stall.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
    output logic [32:0] if_to_id_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    output logic [31:0] fetch_cnt
);

    localparam logic        c_stop     = 1'b1;
    localparam logic [31:0] c_pc_reset = RESET_PC - 32'h4;

    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        br_pend_q, br_pend_d;
    logic [31:0] br_pend_addr_q, br_pend_addr_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    logic        w_br_e;
    logic [31:0] w_br_addr;
    logic [31:0] w_next_pc;
    logic        w_hold;

    // Only bit 0 of the stall vector concerns IF; the rest belong to later stages.
    logic w_unused_stall;
    assign w_unused_stall = &{1'b0, stall[5:1]};

    assign w_br_e    = br_bus[32];
    assign w_br_addr = br_bus[31:0];
    assign w_hold    = (stall[0] == c_stop);

    // A live redirect beats a pending one: it is the newer decision from ID.
    always_comb begin
        w_next_pc = pc_q + 32'h4;
        if (w_br_e) begin
            w_next_pc = w_br_addr;
        end else if (br_pend_q) begin
            w_next_pc = br_pend_addr_q;
        end
    end

    always_comb begin
        pc_d           = pc_q;
        ce_d           = ce_q;
        br_pend_d      = br_pend_q;
        br_pend_addr_d = br_pend_addr_q;
        fetch_cnt_d    = fetch_cnt_q;
        if (!w_hold) begin
            pc_d        = w_next_pc;
            ce_d        = 1'b1;
            br_pend_d   = 1'b0;
            fetch_cnt_d = fetch_cnt_q + 32'h1;
        end else if (w_br_e) begin
            br_pend_d      = 1'b1;
            br_pend_addr_d = w_br_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= c_pc_reset;
            ce_q           <= 1'b0;
            br_pend_q      <= 1'b0;
            br_pend_addr_q <= 32'h0;
            fetch_cnt_q    <= 32'h0;
        end else begin
            pc_q           <= pc_d;
            ce_q           <= ce_d;
            br_pend_q      <= br_pend_d;
            br_pend_addr_q <= br_pend_addr_d;
            fetch_cnt_q    <= fetch_cnt_d;
        end
    end

    assign if_to_id_bus    = {ce_q, pc_q};
    assign inst_sram_en    = ce_q;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0;
    assign fetch_cnt       = fetch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Scoreboard bench for inst_fetch - directed scenarios plus a
//            random stall/redirect phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] fetch_cnt;

    inst_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .fetch_cnt       (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [32:0] bus;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state of the fetch stage
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_pend;
    logic [31:0] m_pend_addr;
    logic [31:0] m_cnt;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic sample_and_compare(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue_empty"}, 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        check_val({tag, "_bus"}, {31'b0, if_to_id_bus}, {31'b0, e.bus});
        check_val({tag, "_en"},  {63'b0, inst_sram_en}, {63'b0, e.bus[32]});
        check_val({tag, "_addr"}, {32'b0, inst_sram_addr}, {32'b0, e.bus[31:0]});
        check_val({tag, "_cnt"}, {32'b0, fetch_cnt}, {32'b0, e.cnt});
        check_val({tag, "_wen"}, {60'b0, inst_sram_wen}, 64'd0);
        check_val({tag, "_wdata"}, {32'b0, inst_sram_wdata}, 64'd0);
    endtask

    task automatic do_reset(input string tag);
        rst    = 1'b1;
        stall  = 6'b0;
        br_bus = 33'b0;
        m_pc        = 32'hBFBF_FFFC;
        m_ce        = 1'b0;
        m_pend      = 1'b0;
        m_pend_addr = 32'h0;
        m_cnt       = 32'h0;
        exp_q.push_back('{bus: {m_ce, m_pc}, cnt: m_cnt});
        @(posedge clk);
        #1;
        sample_and_compare(tag);
    endtask

    task automatic step(input string tag, input logic s0, input logic be, input logic [31:0] ba);
        rst    = 1'b0;
        stall  = {5'b10101, s0};
        br_bus = {be, ba};
        if (!s0) begin
            m_pc   = be ? ba : (m_pend ? m_pend_addr : m_pc + 32'h4);
            m_ce   = 1'b1;
            m_pend = 1'b0;
            m_cnt  = m_cnt + 32'h1;
        end else if (be) begin
            m_pend      = 1'b1;
            m_pend_addr = ba;
        end
        exp_q.push_back('{bus: {m_ce, m_pc}, cnt: m_cnt});
        @(posedge clk);
        #1;
        sample_and_compare(tag);
    endtask

    initial begin
        rst    = 1'b1;
        stall  = 6'b0;
        br_bus = 33'b0;
        @(posedge clk);
        #1;
        do_reset("reset");
        check_val("reset_addr_const", {32'b0, inst_sram_addr}, 64'h0000_0000_BFBF_FFFC);
        check_val("reset_en_const", {63'b0, inst_sram_en}, 64'd0);

        // Free run from reset
        step("run0", 1'b0, 1'b0, 32'h0);
        check_val("first_fetch", {31'b0, if_to_id_bus}, {31'b0, 1'b1, 32'hBFC0_0000});
        step("run1", 1'b0, 1'b0, 32'h0);
        check_val("run1_addr", {32'b0, inst_sram_addr}, 64'h0000_0000_BFC0_0004);
        step("run2", 1'b0, 1'b0, 32'h0);
        check_val("run2_addr", {32'b0, inst_sram_addr}, 64'h0000_0000_BFC0_0008);
        check_val("run_cnt3", {32'b0, fetch_cnt}, 64'd3);

        // Redirect while running
        step("br_run", 1'b0, 1'b1, 32'hBFC0_0100);
        check_val("br_run_addr", {32'b0, inst_sram_addr}, 64'h0000_0000_BFC0_0100);
        step("br_run_next", 1'b0, 1'b0, 32'h0);
        check_val("br_run_next_addr", {32'b0, inst_sram_addr}, 64'h0000_0000_BFC0_0104);

        // Redirect captured during a 3-cycle stall
        step("stall0", 1'b1, 1'b0, 32'h0);
        step("stall1", 1'b1, 1'b1, 32'h8000_0040);
        step("stall2", 1'b1, 1'b0, 32'h0);
        check_val("stall_addr_frozen", {32'b0, inst_sram_addr}, 64'h0000_0000_BFC0_0104);
        check_val("stall_cnt_frozen", {32'b0, fetch_cnt}, 64'd5);
        step("stall_rel", 1'b0, 1'b0, 32'h0);
        check_val("pend_taken", {32'b0, inst_sram_addr}, 64'h0000_0000_8000_0040);
        step("after_pend", 1'b0, 1'b0, 32'h0);
        check_val("after_pend_addr", {32'b0, inst_sram_addr}, 64'h0000_0000_8000_0044);

        // Live redirect on the release edge beats the pending one
        step("ovr0", 1'b1, 1'b1, 32'h8000_0040);
        step("ovr1", 1'b1, 1'b0, 32'h0);
        step("ovr_rel", 1'b0, 1'b1, 32'h8000_0080);
        check_val("live_wins", {32'b0, inst_sram_addr}, 64'h0000_0000_8000_0080);
        step("ovr_after", 1'b0, 1'b0, 32'h0);
        check_val("pend_cleared", {32'b0, inst_sram_addr}, 64'h0000_0000_8000_0084);

        // Later redirect during the same stall overwrites the captured one
        step("ow0", 1'b1, 1'b1, 32'h1000_0000);
        step("ow1", 1'b1, 1'b1, 32'h2000_0000);
        step("ow_rel", 1'b0, 1'b0, 32'h0);
        check_val("overwrite", {32'b0, inst_sram_addr}, 64'h0000_0000_2000_0000);

        // PC wrap
        step("wrap_br", 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("wrap", 1'b0, 1'b0, 32'h0);
        check_val("wrap_addr", {32'b0, inst_sram_addr}, 64'd0);

        // Reset with a redirect pending
        step("rp0", 1'b1, 1'b1, 32'h8000_0200);
        do_reset("rst_pend");
        check_val("rst_pend_bus", {31'b0, if_to_id_bus}, {31'b0, 1'b0, 32'hBFBF_FFFC});
        step("rst_pend_first", 1'b0, 1'b0, 32'h0);
        check_val("rst_pend_discard", {32'b0, inst_sram_addr}, 64'h0000_0000_BFC0_0000);

        // Random stalls and redirects
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                     {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
            end
        end

        check_val("queue_drained", {32'b0, 32'(exp_q.size())}, 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
